// File: rtl/outpkt_bcrypt_src.sv
// ----------------------------------------------------------------------------
// outpkt_bcrypt_src
//
// Source stage in front of the bcrypt output-packet formatter. It gathers
// 16-word result records from the core-side arbiter into a two-bank buffer,
// and holds at most one pending "packet done" event. It presents one item at
// a time to the formatter. The header fields stay registered and stable, and
// the record words are read asynchronously through rd_addr/dout. The item is
// released by the formatter's single-cycle write handshake (wr_en).
//
// Ports:
//   CLK, rst            clock, synchronous active-high reset
//   res_wr_en/res_din   result word write (word 1 = pkt_id)
//   res_cmp/hash_num    record attributes, sampled with word 15
//   res_full            write bank busy, writes ignored
//   done_wr_en/...      packet-done event post
//   done_full           done slot occupied, posts ignored
//   source_not_empty    an item is selected, its fields are stable
//   pkt_type/pkt_id/hash_num/num_processed   registered item header
//   rd_addr/dout        asynchronous word read from the selected bank
//   full/wr_en          formatter backpressure / accept pulse
// ----------------------------------------------------------------------------
`ifndef OUTPKT_TYPE_MSB
`define OUTPKT_TYPE_MSB 2
`endif
`ifndef OUTPKT_TYPE_PACKET_DONE
`define OUTPKT_TYPE_PACKET_DONE 3'd2
`endif
`ifndef OUTPKT_TYPE_RESULT
`define OUTPKT_TYPE_RESULT 3'd3
`endif
`ifndef OUTPKT_TYPE_CMP_RESULT
`define OUTPKT_TYPE_CMP_RESULT 3'd4
`endif

module outpkt_bcrypt_src #(
    parameter int PKT_TYPE_MSB = `OUTPKT_TYPE_MSB,
    parameter int HASH_NUM_MSB = 15
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic                    res_wr_en,
    input  logic [15:0]             res_din,
    input  logic                    res_cmp,
    input  logic [HASH_NUM_MSB:0]   res_hash_num,
    output logic                    res_full,
    input  logic                    done_wr_en,
    input  logic [15:0]             done_pkt_id,
    input  logic [31:0]             done_num_processed,
    output logic                    done_full,
    output logic                    source_not_empty,
    output logic [PKT_TYPE_MSB:0]   pkt_type,
    output logic [15:0]             pkt_id,
    output logic [HASH_NUM_MSB:0]   hash_num,
    output logic [31:0]             num_processed,
    input  logic [3:0]              rd_addr,
    output logic [15:0]             dout,
    input  logic                    full,
    output logic                    wr_en
);

    localparam logic [PKT_TYPE_MSB:0] TYPE_RESULT      = `OUTPKT_TYPE_RESULT;
    localparam logic [PKT_TYPE_MSB:0] TYPE_CMP_RESULT  = `OUTPKT_TYPE_CMP_RESULT;
    localparam logic [PKT_TYPE_MSB:0] TYPE_PACKET_DONE = `OUTPKT_TYPE_PACKET_DONE;

    typedef enum logic [1:0] {
        SEL_IDLE,
        SEL_RESULT,
        SEL_DONE
    } sel_state_e;

    // Two record banks plus per-bank attributes captured with word 15.
    logic [15:0]           mem_q       [2][16];
    logic [1:0]            bank_cmp_q;
    logic [HASH_NUM_MSB:0] bank_hash_q [2];

    logic [1:0]            bank_full_q, bank_full_d;
    logic                  wr_bank_q;
    logic [3:0]            wr_cnt_q;
    logic                  rd_bank_q;
    logic                  done_pending_q;
    logic [15:0]           done_pkt_id_q;
    logic [31:0]           done_num_q;
    sel_state_e            sel_q;

    logic [PKT_TYPE_MSB:0] pkt_type_q;
    logic [15:0]           pkt_id_q;
    logic [HASH_NUM_MSB:0] hash_num_q;
    logic [31:0]           num_processed_q;

    logic res_wr, res_last, done_wr, sel_valid, res_accept;

    assign res_full   = bank_full_q[wr_bank_q];
    assign done_full  = done_pending_q;
    assign res_wr     = res_wr_en & ~res_full;
    assign res_last   = res_wr & (wr_cnt_q == 4'd15);
    assign done_wr    = done_wr_en & ~done_pending_q;
    assign sel_valid  = (sel_q != SEL_IDLE);
    assign wr_en      = sel_valid & ~full;
    assign res_accept = (sel_q == SEL_RESULT) & ~full;

    assign source_not_empty = sel_valid;
    assign pkt_type         = pkt_type_q;
    assign pkt_id           = pkt_id_q;
    assign hash_num         = hash_num_q;
    assign num_processed    = num_processed_q;
    assign dout             = mem_q[rd_bank_q][rd_addr];

    // Release of the read bank and completion of the write bank may coincide.
    // They always hit different banks, so both updates apply.
    always_comb begin
        // NOTE: assign a default before any condition so no latch is inferred.
        bank_full_d = bank_full_q;
        if (res_accept) bank_full_d[rd_bank_q] = 1'b0;
        if (res_last)   bank_full_d[wr_bank_q] = 1'b1;
    end

    // NOTE: the storage has no reset. Its contents are only meaningful while
    // bank_full is set, so it can map onto distributed RAM.
    always_ff @(posedge CLK) begin
        if (res_wr) mem_q[wr_bank_q][wr_cnt_q] <= res_din;
        if (res_last) begin
            bank_cmp_q[wr_bank_q]  <= res_cmp;
            bank_hash_q[wr_bank_q] <= res_hash_num;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments.
    always_ff @(posedge CLK) begin
        if (rst) begin
            bank_full_q     <= 2'b00;
            wr_bank_q       <= 1'b0;
            wr_cnt_q        <= 4'd0;
            rd_bank_q       <= 1'b0;
            done_pending_q  <= 1'b0;
            done_pkt_id_q   <= '0;
            done_num_q      <= '0;
            sel_q           <= SEL_IDLE;
            pkt_type_q      <= '0;
            pkt_id_q        <= '0;
            hash_num_q      <= '0;
            num_processed_q <= '0;
        end else begin
            bank_full_q <= bank_full_d;
            if (res_wr)   wr_cnt_q  <= wr_cnt_q + 4'd1;
            if (res_last) wr_bank_q <= ~wr_bank_q;

            if (done_wr) begin
                done_pending_q <= 1'b1;
                done_pkt_id_q  <= done_pkt_id;
                done_num_q     <= done_num_processed;
            end

            unique case (sel_q)
                SEL_IDLE: begin
                    if (bank_full_q[rd_bank_q]) begin
                        sel_q      <= SEL_RESULT;
                        pkt_type_q <= bank_cmp_q[rd_bank_q] ? TYPE_CMP_RESULT : TYPE_RESULT;
                        pkt_id_q   <= mem_q[rd_bank_q][4'd1];
                        hash_num_q <= bank_hash_q[rd_bank_q];
                    // A done event waits until no result data is buffered or
                    // being filled, so it never overtakes its packet's results.
                    end else if (done_pending_q && wr_cnt_q == 4'd0 && bank_full_q == 2'b00) begin
                        sel_q           <= SEL_DONE;
                        pkt_type_q      <= TYPE_PACKET_DONE;
                        pkt_id_q        <= done_pkt_id_q;
                        num_processed_q <= done_num_q;
                    end
                end
                SEL_RESULT: begin
                    if (!full) begin
                        sel_q     <= SEL_IDLE;
                        rd_bank_q <= ~rd_bank_q;
                    end
                end
                SEL_DONE: begin
                    if (!full) begin
                        sel_q          <= SEL_IDLE;
                        done_pending_q <= 1'b0;
                    end
                end
                default: sel_q <= SEL_IDLE;
            endcase
        end
    end

endmodule
